// File: rtl/my_gatesnway_seq.sv
// ============================================================================
//  Module   : my_gatesnway_seq
//  Purpose  : Registered N-way word select with AND/OR reduction and 1-bit
//             demux, behind a single-stage valid/ready output register.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module my_gatesnway_seq #(
  parameter int  WAYS  = 8,
  parameter int  WIDTH = 16,
  localparam int SELW  = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WAYS*WIDTH-1:0] in,
  input  logic [SELW-1:0]       sel,
  input  logic                  mode,
  input  logic                  din,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_mux,
  output logic [SELW-1:0]       out_sel,
  output logic                  out_and,
  output logic                  out_or,
  output logic [WAYS-1:0]       out_dmux
);

  logic [WIDTH-1:0] w_chan [WAYS];
  logic [SELW-1:0]  w_eff_sel;
  logic [WIDTH-1:0] w_word;
  logic             w_accept;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_mux_q,   out_mux_d;
  logic [SELW-1:0]  out_sel_q,   out_sel_d;
  logic             out_and_q,   out_and_d;
  logic             out_or_q,    out_or_d;
  logic [WAYS-1:0]  out_dmux_q,  out_dmux_d;
  logic [SELW-1:0]  scan_ptr_q,  scan_ptr_d;

  generate
    for (genvar k = 0; k < WAYS; k++) begin : g_chan
      assign w_chan[k] = in[k*WIDTH +: WIDTH];
    end
  endgenerate

  assign w_eff_sel = mode ? scan_ptr_q : sel;
  assign w_word    = w_chan[w_eff_sel];

  // Ready only depends on the output stage, never on in_valid.
  assign in_ready  = rst_n && (!out_valid_q || out_ready);
  assign w_accept  = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_mux_d   = out_mux_q;
    out_sel_d   = out_sel_q;
    out_and_d   = out_and_q;
    out_or_d    = out_or_q;
    out_dmux_d  = out_dmux_q;
    scan_ptr_d  = scan_ptr_q;
    if (w_accept) begin
      out_valid_d = 1'b1;
      out_mux_d   = w_word;
      out_sel_d   = w_eff_sel;
      out_and_d   = &w_word;
      out_or_d    = |w_word;
      out_dmux_d  = {{(WAYS-1){1'b0}}, din} << w_eff_sel;
      if (mode) begin
        scan_ptr_d = scan_ptr_q + SELW'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_mux_q   <= '0;
      out_sel_q   <= '0;
      out_and_q   <= 1'b0;
      out_or_q    <= 1'b0;
      out_dmux_q  <= '0;
      scan_ptr_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_mux_q   <= out_mux_d;
      out_sel_q   <= out_sel_d;
      out_and_q   <= out_and_d;
      out_or_q    <= out_or_d;
      out_dmux_q  <= out_dmux_d;
      scan_ptr_q  <= scan_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_mux   = out_mux_q;
  assign out_sel   = out_sel_q;
  assign out_and   = out_and_q;
  assign out_or    = out_or_q;
  assign out_dmux  = out_dmux_q;

endmodule

`default_nettype wire

// File: tb/tb_my_gatesnway_seq.sv
// ============================================================================
//  Module   : tb_my_gatesnway_seq
//  Purpose  : Directed bench for my_gatesnway_seq (8x16) plus 4x8 streaming.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_my_gatesnway_seq;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 8 x 16 instance
  logic [127:0] a_in;
  logic [2:0]   a_sel, a_out_sel;
  logic         a_mode, a_din, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [15:0]  a_out_mux;
  logic         a_out_and, a_out_or;
  logic [7:0]   a_out_dmux;

  my_gatesnway_seq #(.WAYS(8), .WIDTH(16)) u_a (
    .clk(clk), .rst_n(rst_n), .in(a_in), .sel(a_sel), .mode(a_mode), .din(a_din),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_mux(a_out_mux), .out_sel(a_out_sel),
    .out_and(a_out_and), .out_or(a_out_or), .out_dmux(a_out_dmux)
  );

  // 4 x 8 instance
  logic [31:0] b_in;
  logic [1:0]  b_sel, b_out_sel;
  logic        b_mode, b_din, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_out_mux;
  logic        b_out_and, b_out_or;
  logic [3:0]  b_out_dmux;

  my_gatesnway_seq #(.WAYS(4), .WIDTH(8)) u_b (
    .clk(clk), .rst_n(rst_n), .in(b_in), .sel(b_sel), .mode(b_mode), .din(b_din),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_mux(b_out_mux), .out_sel(b_out_sel),
    .out_and(b_out_and), .out_or(b_out_or), .out_dmux(b_out_dmux)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_outs(input string tag, input logic v, input logic [15:0] m,
                        input logic [2:0] s, input logic an, input logic o,
                        input logic [7:0] d);
    chk({tag, "_valid"}, 32'(a_out_valid), 32'(v));
    chk({tag, "_mux"},   32'(a_out_mux),   32'(m));
    chk({tag, "_sel"},   32'(a_out_sel),   32'(s));
    chk({tag, "_and"},   32'(a_out_and),   32'(an));
    chk({tag, "_or"},    32'(a_out_or),    32'(o));
    chk({tag, "_dmux"},  32'(a_out_dmux),  32'(d));
  endtask

  // Streaming model state for the 4x8 instance
  logic [15:0] sb_q[$];
  logic [1:0]  m_ptr;
  logic [1:0]  m_es;
  logic [7:0]  m_w;
  logic        acc, drn, b_fresh;
  logic [15:0] head;

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    a_in = '0; a_sel = '0; a_mode = 1'b0; a_din = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    b_in = '0; b_sel = '0; b_mode = 1'b0; b_din = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;

    // Reset, then direct fill
    step(); step();
    chk("rst_in_ready_low", 32'(a_in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    a_outs("rst", 1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 8'h0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);

    a_in[5*16 +: 16] = 16'hFFFF; a_sel = 3'd5; a_din = 1'b1; a_in_valid = 1'b1;
    step();
    a_outs("fill5", 1'b1, 16'hFFFF, 3'd5, 1'b1, 1'b1, 8'b0010_0000);

    // Reductions on channel 2
    a_in[2*16 +: 16] = 16'h0000; a_sel = 3'd2; a_din = 1'b0;
    step();
    a_outs("red0", 1'b1, 16'h0000, 3'd2, 1'b0, 1'b0, 8'h00);
    a_in[2*16 +: 16] = 16'h0100; a_din = 1'b1;
    step();
    a_outs("red100", 1'b1, 16'h0100, 3'd2, 1'b0, 1'b1, 8'b0000_0100);

    // Back-pressure with a pending beat on channel 3
    a_out_ready = 1'b0;
    a_in[3*16 +: 16] = 16'h1234; a_sel = 3'd3; a_din = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", 32'(a_in_ready), 32'd0);
      step();
      a_outs("bp_hold", 1'b1, 16'h0100, 3'd2, 1'b0, 1'b1, 8'b0000_0100);
    end
    a_out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(a_in_ready), 32'd1);
    step();
    a_outs("bp_load", 1'b1, 16'h1234, 3'd3, 1'b0, 1'b1, 8'b0000_1000);
    a_in_valid = 1'b0;
    step();
    chk("drain_valid", 32'(a_out_valid), 32'd0);
    chk("drain_hold_mux", 32'(a_out_mux), 32'h1234);

    // Scan wrap over 10 beats
    for (int k = 0; k < 8; k++) a_in[k*16 +: 16] = 16'(k) * 16'h0101;
    a_mode = 1'b1; a_din = 1'b1; a_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("scan_sel", 32'(a_out_sel), 32'(i % 8));
      chk("scan_mux", 32'(a_out_mux), 32'((i % 8) * 16'h0101));
      chk("scan_dmux", 32'(a_out_dmux), 32'(8'h01 << (i % 8)));
    end
    step();
    chk("scan_sel_10", 32'(a_out_sel), 32'd2);

    // Direct beats leave the scan pointer (now 3) untouched
    a_mode = 1'b0; a_sel = 3'd6;
    step();
    chk("dir_sel_a", 32'(a_out_sel), 32'd6);
    step();
    chk("dir_sel_b", 32'(a_out_sel), 32'd6);
    chk("dir_mux", 32'(a_out_mux), 32'h0606);
    a_mode = 1'b1;
    step();
    chk("rescan_sel", 32'(a_out_sel), 32'd3);

    // Reset during a hold
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    step();
    chk("hold_valid", 32'(a_out_valid), 32'd1);
    rst_n = 1'b0;
    step();
    a_outs("midrst", 1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 8'h0);
    rst_n = 1'b1; a_out_ready = 1'b1;
    step();
    chk("post_rst_no_pulse", 32'(a_out_valid), 32'd0);
    a_in_valid = 1'b1;
    step();
    chk("post_rst_scan_sel", 32'(a_out_sel), 32'd0);
    chk("post_rst_scan_mux", 32'(a_out_mux), 32'h0000);
    a_in_valid = 1'b0;

    // 4x8 streaming with random back-pressure and in-order scoreboard
    m_ptr = '0;
    b_fresh = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (b_fresh) begin
        b_in       = $urandom;
        b_sel      = 2'($urandom_range(0, 3));
        b_mode     = 1'($urandom_range(0, 1));
        b_din      = 1'($urandom_range(0, 1));
        b_in_valid = ($urandom_range(0, 3) != 0);
      end
      b_out_ready = ($urandom_range(0, 2) != 0);
      #1;
      acc = b_in_valid && b_in_ready;
      drn = b_out_valid && b_out_ready;
      if (drn) begin
        if (sb_q.size() == 0) begin
          chk("stream_unexpected", 32'd1, 32'd0);
        end else begin
          head = sb_q.pop_front();
          chk("stream_beat", 32'({b_out_sel, b_out_mux, b_out_and, b_out_or, b_out_dmux}), 32'(head));
        end
      end
      if (acc) begin
        m_es = b_mode ? m_ptr : b_sel;
        m_w  = b_in[m_es*8 +: 8];
        sb_q.push_back({m_es, m_w, (m_w == 8'hFF), (m_w != 8'h00), 4'(b_din) << m_es});
        if (b_mode) m_ptr = m_ptr + 2'd1;
      end
      b_fresh = acc || !b_in_valid;
      step();
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    #1;
    if (b_out_valid) begin
      if (sb_q.size() == 0) begin
        chk("stream_tail_unexpected", 32'd1, 32'd0);
      end else begin
        head = sb_q.pop_front();
        chk("stream_tail", 32'({b_out_sel, b_out_mux, b_out_and, b_out_or, b_out_dmux}), 32'(head));
      end
    end
    step();
    chk("stream_empty", 32'(sb_q.size()), 32'd0);
    chk("stream_idle", 32'(b_out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
